demux_tdm_rx: RTL and testbench
===============================

// Module: demux_tdm_rx
// PURPOSE
//  Time-division demultiplexer: the receive end of a serial TDM link built from
//  the team's mux primitives. It takes a 1-bit stream with a frame-sync marker
//  and splits each frame of N_CH channels x W bits back into per-channel
//  parallel registers, each with a one-cycle valid strobe. It sits after the
//  serial link and before the per-channel consumers.
// PARAMETERS
//  N_CH    2   channels per frame (>=2)
//  W       8   bits per channel, MSB first (>=2)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous, active-low reset
//  din        in   1         serial data bit
//  din_valid  in   1         qualifies din/frame_sync; all logic holds when 0
//  frame_sync in   1         high with bit 0 (MSB of ch0) of every frame
//  dout       out  N_CH*W    channel registers; ch k = dout[k*W +: W]
//  ch_valid   out  N_CH      one-hot pulse; bit k = ch k just updated
//  frame_done out  1         pulse; last channel of frame just updated
//  sync_err   out  1         pulse; frame_sync early or missing
//  locked     out  1         high after a clean full frame
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain; rst_n is asynchronous, active-low.
//  - Reset clears every output and register: dout=0, ch_valid=0, frame_done=0,
//    sync_err=0, locked=0, state=IDLE, bit_cnt=0, ch_cnt=0.
//  - Reset asserted mid-frame aborts the frame. No partial channel is written.
//  - A cycle is consumed only when din_valid=1. Otherwise all state holds and
//    all pulse outputs are 0.
//  State machine
//  - IDLE: locked=0. A consumed cycle with frame_sync=1 shifts din in as bit 0
//    and sets bit_cnt=1, ch_cnt=0, state=RECV. Other consumed cycles are
//    discarded.
//  - RECV, normal bit: shift din into the SIPO and increment bit_cnt.
//  - RECV, bit_cnt==W-1: write {shreg[W-2:0],din} to channel ch_cnt.
//    - ch_valid[ch_cnt] pulses, registered: visible with the new dout.
//    - bit_cnt wraps to 0 and ch_cnt increments.
//  - RECV, ch_cnt==N_CH-1 at its last bit:
//    - frame_done pulses and locked<=1.
//    - ch_cnt wraps to 0; the frame boundary is now expected.
//  - RECV, at the boundary (bit_cnt==0, ch_cnt==0):
//    - frame_sync=1: normal bit 0 of the next frame (back-to-back frames).
//    - frame_sync=0: sync_err pulses, locked<=0, state=IDLE, bit discarded.
//  - RECV, frame_sync=1 anywhere other than the boundary (early sync):
//    - sync_err pulses and locked<=0.
//    - The partial channel is dropped; dout keeps its old values.
//    - The frame restarts with this bit as bit 0 (bit_cnt=1, ch_cnt=0).
//  Latency and width rules
//  - Channel data appears on dout the cycle after its last bit is sampled.
//  - dout holds until that channel is rewritten.
//  - Counters are $clog2 sized. They never take values >= W or >= N_CH.
// STRUCTURE
//  - Shared package demux_tdm_pkg holds:
//    - state encoding ST_IDLE=1'b0, ST_RECV=1'b1
//    - helper CLOG2 used for counter widths
//  - Sub-module sipo_shift #(W): W-bit shift-in register with enable and
//    asynchronous active-low clear; presents {q[W-2:0],d} for the write.
//  - The top level holds the FSM, bit/ch counters, the channel register bank
//    and the pulse registers.
// TESTING (N_CH=2, W=8)
//  1. sync + bits A5,3C contiguous:
//     dout[7:0]=A5 with ch_valid=01, then dout[15:8]=3C with ch_valid=10
//     and frame_done=1; locked=1.
//  2. Same frame with din_valid=0 gaps of 1-3 cycles:
//     identical outputs; no pulse during any gap cycle.
//  3. Two back-to-back frames (A5,3C then 5A,C3), sync on each bit 0:
//     4 ch_valid pulses, 2 frame_done pulses, locked stays 1, sync_err=0.
//  4. frame_sync at bit 5 of ch1:
//     sync_err=1 for 1 cycle, locked=0, dout[15:8] unchanged;
//     the next 16 bits decode as a new frame.
//  5. No frame_sync after a completed frame:
//     sync_err=1, state IDLE, following bits ignored until the next sync.
//  6. rst_n low mid-ch0:
//     all outputs 0 immediately, without waiting for a clock;
//     after release, a full frame decodes correctly.

Source files
------------

// File: rtl/demux_tdm_pkg.sv
// Shared types and helpers for the TDM receive path.
package demux_tdm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  // Minimum bit width to hold 0..value-1; never less than 1 bit.
  function automatic int CLOG2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// W-bit serial-in shift register, MSB first; word is the value the register would hold after
// shifting in d, so the top level can write a channel on its last bit without an extra cycle.
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q,
  output logic [W-1:0] word
);

  assign word = {q[W-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (en) q <= word;
  end

endmodule

// File: rtl/demux_tdm_rx.sv
// Serial TDM frame receiver: splits N_CH x W-bit frames into channel registers.
// Channel data and its strobe appear one cycle after the last bit; din_valid=0 freezes all state.
module demux_tdm_rx
  import demux_tdm_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [N_CH*W-1:0] dout,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  localparam int BW = CLOG2(W);
  localparam int CW = CLOG2(N_CH);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(N_CH - 1);

  state_t          state, state_nxt;
  logic [BW-1:0]   bit_cnt, bit_nxt;
  logic [CW-1:0]   ch_cnt, ch_nxt;
  logic            shift_en, wr_en, fd_nxt, err_nxt, lock_nxt;
  logic            at_boundary, early_sync, last_bit;
  logic [W-1:0]    shreg, word;

  sipo_shift #(.W(W)) u_sipo (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (shift_en),
    .d    (din),
    .q    (shreg),
    .word (word)
  );

  assign at_boundary = (bit_cnt == '0) && (ch_cnt == '0);
  assign early_sync  = frame_sync && !at_boundary;
  assign last_bit    = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (din_valid) begin
      case (state)
        ST_IDLE: if (frame_sync) state_nxt = ST_RECV;
        ST_RECV: if (at_boundary && !frame_sync) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = 1'b0;
    wr_en    = 1'b0;
    fd_nxt   = 1'b0;
    err_nxt  = 1'b0;
    lock_nxt = locked;
    bit_nxt  = bit_cnt;
    ch_nxt   = ch_cnt;
    if (din_valid) begin
      case (state)
        ST_IDLE: begin
          lock_nxt = 1'b0;
          if (frame_sync) begin
            shift_en = 1'b1;
            bit_nxt  = BW'(1);
            ch_nxt   = '0;
          end
        end
        ST_RECV: begin
          if (early_sync) begin
            // Drop the partial channel and treat this bit as bit 0 of a fresh frame.
            err_nxt  = 1'b1;
            lock_nxt = 1'b0;
            shift_en = 1'b1;
            bit_nxt  = BW'(1);
            ch_nxt   = '0;
          end else if (at_boundary && !frame_sync) begin
            err_nxt  = 1'b1;
            lock_nxt = 1'b0;
          end else begin
            shift_en = 1'b1;
            if (last_bit) begin
              wr_en   = 1'b1;
              bit_nxt = '0;
              if (ch_cnt == CH_LAST) begin
                fd_nxt   = 1'b1;
                lock_nxt = 1'b1;
                ch_nxt   = '0;
              end else begin
                ch_nxt = ch_cnt + CW'(1);
              end
            end else begin
              bit_nxt = bit_cnt + BW'(1);
            end
          end
        end
        default: lock_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      ch_cnt     <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      ch_valid   <= '0;
      dout       <= '0;
    end else begin
      bit_cnt    <= bit_nxt;
      ch_cnt     <= ch_nxt;
      locked     <= lock_nxt;
      frame_done <= fd_nxt;
      sync_err   <= err_nxt;
      for (int k = 0; k < N_CH; k++) begin
        ch_valid[k] <= wr_en && (ch_cnt == CW'(k));
        if (wr_en && (ch_cnt == CW'(k))) dout[k*W +: W] <= word;
      end
    end
  end

endmodule

// File: tb/tb_demux_tdm_rx.sv
// Randomized scoreboard bench for demux_tdm_rx with a frame-position reference model.
module tb_demux_tdm_rx;

  localparam int N_CH = 2;
  localparam int W    = 8;
  localparam int FB   = N_CH * W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            din = 1'b0;
  logic            din_valid = 1'b0;
  logic            frame_sync = 1'b0;
  logic [FB-1:0]   dout;
  logic [N_CH-1:0] ch_valid;
  logic            frame_done;
  logic            sync_err;
  logic            locked;

  demux_tdm_rx #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .frame_sync(frame_sync),
    .dout      (dout),
    .ch_valid  (ch_valid),
    .frame_done(frame_done),
    .sync_err  (sync_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              at;
    logic [N_CH-1:0] chv;
    logic            fd;
    logic            se;
    logic [FB-1:0]   dat;
    logic            lk;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: position within the current frame plus accumulated word.
  bit            m_in = 0;
  int            m_pos = 0;
  int            m_acc = 0;
  logic [FB-1:0] m_dout = '0;
  bit            m_locked = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input logic [N_CH-1:0] chv, input logic fd, input logic se);
    ev_t e;
    e.at  = cyc + 1;
    e.chv = chv;
    e.fd  = fd;
    e.se  = se;
    e.dat = m_dout;
    e.lk  = m_locked;
    exp_q.push_back(e);
  endfunction

  function automatic void model_step(input bit d, input bit s);
    int ch;
    if (!m_in) begin
      if (s) begin
        m_in  = 1;
        m_pos = 1;
        m_acc = int'(d);
      end
    end else if (s && m_pos != 0) begin
      m_locked = 0;
      push_ev('0, 1'b0, 1'b1);
      m_pos = 1;
      m_acc = int'(d);
    end else if (!s && m_pos == 0) begin
      m_locked = 0;
      m_in     = 0;
      push_ev('0, 1'b0, 1'b1);
    end else begin
      m_acc = (m_acc * 2 + int'(d)) % (1 << W);
      m_pos++;
      if (m_pos % W == 0) begin
        ch = m_pos / W - 1;
        m_dout[ch*W +: W] = W'(m_acc);
        if (ch == N_CH - 1) m_locked = 1;
        push_ev(N_CH'(1) << ch, ch == N_CH - 1, 1'b0);
        m_acc = 0;
        if (m_pos == FB) m_pos = 0;
      end
    end
  endfunction

  function automatic void model_reset();
    m_in = 0; m_pos = 0; m_acc = 0; m_dout = '0; m_locked = 0;
  endfunction

  task automatic drive(input bit v, input bit d, input bit s);
    @(posedge clk);
    #1;
    din_valid  = v;
    din        = d;
    frame_sync = s;
    if (v) model_step(d, s);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Sends the first nbits of a frame (ch0 first, MSB first), sync on bit 0,
  // optionally with random 1..gaps invalid cycles carrying junk between bits.
  task automatic send_frame(input logic [FB-1:0] vals, input int gaps, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int ch;
      int b;
      ch = i / W;
      b  = W - 1 - (i % W);
      if (gaps > 0 && i > 0 && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, gaps)) drive(1'b0, 1'($urandom), 1'($urandom));
      drive(1'b1, vals[ch*W + b], i == 0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dout"}, 64'(dout), 64'd0);
    chk({tag, "_ch_valid"}, 64'(ch_valid), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_sync_err"}, 64'(sync_err), 64'd0);
    chk({tag, "_locked"}, 64'(locked), 64'd0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (ch_valid != '0 || frame_done || sync_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: ch_valid=%b frame_done=%b sync_err=%b at cycle %0d, expected none",
                 ch_valid, frame_done, sync_err, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(e.at));
        chk("ch_valid", 64'(ch_valid), 64'(e.chv));
        chk("frame_done", 64'(frame_done), 64'(e.fd));
        chk("sync_err", 64'(sync_err), 64'(e.se));
        chk("dout", 64'(dout), 64'(e.dat));
        chk("locked", 64'(locked), 64'(e.lk));
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FB-1:0] v;
    int r;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;
    model_reset();

    // Single clean frame, then the same frame with idle gaps.
    send_frame(16'h3CA5, 0, FB);
    idle(3);
    chk("locked_after_frame", 64'(locked), 64'(m_locked));
    send_frame(16'h3CA5, 3, FB);
    idle(2);

    // Back-to-back frames.
    send_frame(16'h3CA5, 0, FB);
    send_frame(16'hC35A, 0, FB);
    idle(2);
    chk("locked_back_to_back", 64'(locked), 64'd1);

    // Early sync at bit 5 of ch1, then a full frame from that sync.
    send_frame(16'h3CA5, 0, W + 5);
    send_frame(16'h1234, 0, FB);
    idle(2);

    // Missing sync after a complete frame; junk is ignored until the next sync.
    repeat (20) drive(1'b1, 1'($urandom), 1'b0);
    chk("locked_after_missing_sync", 64'(locked), 64'd0);
    send_frame(16'h9E61, 0, FB);
    idle(2);

    // Asynchronous reset mid ch0.
    send_frame(16'h7788, 0, 4);
    @(posedge clk);
    #1 din_valid = 1'b0;
    frame_sync = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(16'hB44B, 0, FB);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      v = FB'($urandom);
      case (r)
        0:       send_frame(v, 1, $urandom_range(1, FB - 1));
        1:       repeat ($urandom_range(1, 5)) drive(1'b1, 1'($urandom), 1'b0);
        2:       idle($urandom_range(1, 3));
        default: send_frame(v, $urandom_range(0, 3), FB);
      endcase
    end

    idle(5);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
